// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, the instruction-memory handshake and a one-entry stall buffer.
module fetch_stage #(
   parameter int WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pred_next_PC,
   output logic [WORD_SIZE-1:0] fetch_PC,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [WORD_SIZE-1:0] redirect_PC,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 i_inputReady,
   output logic [WORD_SIZE-1:0] IFID_instr,
   output logic [WORD_SIZE-1:0] IFID_PC,
   output logic [WORD_SIZE-1:0] IFID_pred_PC,
   output logic                 IFID_valid,
   output logic [WORD_SIZE-1:0] num_fetch
);
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
   state_t               state_q;
   logic [WORD_SIZE-1:0] pc_q, req_addr_q, buf_instr_q, buf_pc_q, buf_pred_q;
   logic [WORD_SIZE-1:0] ifid_instr_q, ifid_pc_q, ifid_pred_q, num_fetch_q;
   logic                 ifid_valid_q;
   assign fetch_PC     = pc_q;
   assign i_readM      = reset_n & (state_q != HOLD);
   assign i_address    = (state_q == DRAIN) ? req_addr_q : pc_q;
   assign IFID_instr   = ifid_instr_q;
   assign IFID_PC      = ifid_pc_q;
   assign IFID_pred_PC = ifid_pred_q;
   assign IFID_valid   = ifid_valid_q;
   assign num_fetch    = num_fetch_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         buf_instr_q  <= '0;
         buf_pc_q     <= '0;
         buf_pred_q   <= '0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_pred_q  <= '0;
         ifid_valid_q <= 1'b0;
         num_fetch_q  <= '0;
      end else begin
         if (state_q == FETCH) req_addr_q <= pc_q;
         // Redirect beats stall and capture; an unfinished read must still complete in DRAIN.
         if (flush) begin
            pc_q         <= redirect_PC;
            ifid_valid_q <= 1'b0;
            state_q      <= (state_q != HOLD && !i_inputReady) ? DRAIN : FETCH;
         end else begin
            case (state_q)
               FETCH: begin
                  if (i_inputReady && stall) begin
                     buf_instr_q <= i_data;
                     buf_pc_q    <= pc_q;
                     buf_pred_q  <= pred_next_PC;
                     state_q     <= HOLD;
                  end else if (i_inputReady) begin
                     ifid_instr_q <= i_data;
                     ifid_pc_q    <= pc_q;
                     ifid_pred_q  <= pred_next_PC;
                     ifid_valid_q <= 1'b1;
                     pc_q         <= pred_next_PC;
                     num_fetch_q  <= num_fetch_q + WORD_SIZE'(1);
                  end else if (!stall) begin
                     ifid_valid_q <= 1'b0;
                  end
               end
               HOLD: begin
                  if (!stall) begin
                     ifid_instr_q <= buf_instr_q;
                     ifid_pc_q    <= buf_pc_q;
                     ifid_pred_q  <= buf_pred_q;
                     ifid_valid_q <= 1'b1;
                     pc_q         <= buf_pred_q;
                     num_fetch_q  <= num_fetch_q + WORD_SIZE'(1);
                     state_q      <= FETCH;
                  end
               end
               DRAIN: if (i_inputReady) state_q <= FETCH;
               default: state_q <= FETCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a PC+offset predictor and an XOR-coded memory.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pred_next_PC, fetch_PC, redirect_PC, i_address, i_data;
   logic [15:0] IFID_instr, IFID_PC, IFID_pred_PC, num_fetch, pred_off;
   logic        stall, flush, i_readM, i_inputReady, IFID_valid;
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   assign pred_next_PC = fetch_PC + pred_off;
   assign i_data       = i_address ^ 16'h6017;
   fetch_stage dut (
      .clk(clk), .reset_n(reset_n), .pred_next_PC(pred_next_PC), .fetch_PC(fetch_PC),
      .stall(stall), .flush(flush), .redirect_PC(redirect_PC), .i_readM(i_readM),
      .i_address(i_address), .i_data(i_data), .i_inputReady(i_inputReady),
      .IFID_instr(IFID_instr), .IFID_PC(IFID_PC), .IFID_pred_PC(IFID_pred_PC),
      .IFID_valid(IFID_valid), .num_fetch(num_fetch)
   );
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_PC = 16'h0000;
      i_inputReady = 1'b1; pred_off = 16'h0001;
      #3;
      chk("rst_readM", 16'(i_readM), 16'h0000);
      chk("rst_valid", 16'(IFID_valid), 16'h0000);
      chk("rst_num", num_fetch, 16'h0000);
      chk("rst_pc", fetch_PC, 16'h0000);
      chk("rst_instr", IFID_instr, 16'h0000);
      #9 reset_n = 1'b1;
      #1;
      chk("rel_readM", 16'(i_readM), 16'h0001);
      chk("rel_addr", i_address, 16'h0000);
      // zero-wait streaming
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("zw_addr", i_address, 16'(k));
         chk("zw_num", num_fetch, 16'(k));
      end
      chk("zw_ifpc", IFID_PC, 16'h0003);
      chk("zw_instr", IFID_instr, 16'h6014);
      chk("zw_pred", IFID_pred_PC, 16'h0004);
      chk("zw_valid", 16'(IFID_valid), 16'h0001);
      // two-cycle latency
      i_inputReady = 1'b0; step();
      chk("lat_bubble", 16'(IFID_valid), 16'h0000);
      chk("lat_addr", i_address, 16'h0004);
      chk("lat_num", num_fetch, 16'h0004);
      i_inputReady = 1'b1; step();
      chk("lat_ifpc", IFID_PC, 16'h0004);
      chk("lat_valid", 16'(IFID_valid), 16'h0001);
      chk("lat_num2", num_fetch, 16'h0005);
      i_inputReady = 1'b0; step();
      chk("lat_bubble2", 16'(IFID_valid), 16'h0000);
      chk("lat_addr2", i_address, 16'h0005);
      // stall on capture of PC=5, predictor says 7 only on that cycle
      i_inputReady = 1'b1; stall = 1'b1; pred_off = 16'h0002; step();
      pred_off = 16'h0001;
      for (int k = 0; k < 3; k++) begin
         chk("hold_readM", 16'(i_readM), 16'h0000);
         chk("hold_ifpc", IFID_PC, 16'h0004);
         chk("hold_pc", fetch_PC, 16'h0005);
         if (k < 2) step();
      end
      stall = 1'b0; step();
      chk("hold_instr", IFID_instr, 16'h6012);
      chk("hold_ifpc2", IFID_PC, 16'h0005);
      chk("hold_pred", IFID_pred_PC, 16'h0007);
      chk("hold_valid", 16'(IFID_valid), 16'h0001);
      chk("hold_pc2", fetch_PC, 16'h0007);
      chk("hold_num", num_fetch, 16'h0006);
      // flush while request to PC=7 waits
      i_inputReady = 1'b0; step();
      chk("fl_wait_addr", i_address, 16'h0007);
      flush = 1'b1; redirect_PC = 16'h0040; step();
      flush = 1'b0;
      chk("dr_addr", i_address, 16'h0007);
      chk("dr_readM", 16'(i_readM), 16'h0001);
      chk("dr_pc", fetch_PC, 16'h0040);
      chk("dr_valid", 16'(IFID_valid), 16'h0000);
      step();
      chk("dr_addr2", i_address, 16'h0007);
      i_inputReady = 1'b1; step();
      chk("dr_done_addr", i_address, 16'h0040);
      chk("dr_done_valid", 16'(IFID_valid), 16'h0000);
      chk("dr_done_num", num_fetch, 16'h0006);
      step();
      chk("rd_ifpc", IFID_PC, 16'h0040);
      chk("rd_valid", 16'(IFID_valid), 16'h0001);
      chk("rd_num", num_fetch, 16'h0007);
      // flush+stall while in HOLD
      stall = 1'b1; step();
      chk("h2_readM", 16'(i_readM), 16'h0000);
      flush = 1'b1; redirect_PC = 16'h0080; step();
      flush = 1'b0;
      chk("fs_valid", 16'(IFID_valid), 16'h0000);
      chk("fs_pc", fetch_PC, 16'h0080);
      chk("fs_readM", 16'(i_readM), 16'h0001);
      chk("fs_num", num_fetch, 16'h0007);
      stall = 1'b0; step();
      chk("fs_ifpc", IFID_PC, 16'h0080);
      chk("fs_num2", num_fetch, 16'h0008);
      // PC wrap through the predictor
      flush = 1'b1; redirect_PC = 16'hFFFF; step();
      flush = 1'b0;
      chk("wr_pc", fetch_PC, 16'hFFFF);
      step();
      chk("wr_ifpc", IFID_PC, 16'hFFFF);
      chk("wr_pc2", fetch_PC, 16'h0000);
      // async reset mid-wait
      i_inputReady = 1'b0; step();
      #2 reset_n = 1'b0;
      #1;
      chk("ar_readM", 16'(i_readM), 16'h0000);
      chk("ar_pc", fetch_PC, 16'h0000);
      chk("ar_num", num_fetch, 16'h0000);
      chk("ar_ifpc", IFID_PC, 16'h0000);
      chk("ar_instr", IFID_instr, 16'h0000);
      #1 reset_n = 1'b1; i_inputReady = 1'b1;
      #1;
      chk("ar_addr", i_address, 16'h0000);
      step();
      chk("ar_ifpc2", IFID_PC, 16'h0000);
      chk("ar_num2", num_fetch, 16'h0001);
      chk("ar_valid2", 16'(IFID_valid), 16'h0001);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
